idct2d_sched: RTL and testbench
===============================

Name: idct2d_sched

Overview:
Sequences one shared 1D loeffler_idct instance through the row pass and then the column pass of an 8x8 JPEG block. Inputs are coefficient rows from the dequantiser; outputs are pixel rows to colour conversion. Owns the 8x8 transpose buffer and the 8x8 output buffer. Performs the final scale, +128 level shift and clamp.

Parameters:
IN_W, 12, signed coefficient width per input element
MID_W, 16, signed width of transpose-buffer entries; row results saturate to this width
OUT_SHIFT, 3, arithmetic right shift, with rounding, applied to column results
CH_W, 2, channel tag width
TIMEOUT, 255, cycles allowed in a WAIT state before an error (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low (asserted when 0)
in_valid  in  1  input coefficient row valid
in_ready  out  1  input row accepted when in_valid && in_ready
in_row  in  8*IN_W  8 signed coefficients; element 0 in the LSBs
in_ch  in  CH_W  channel tag, sampled on row 0 only
idct_valid_in  out  1  to loeffler_idct valid_in
idct_channel_in  out  CH_W  to loeffler_idct channel_in
idct_in  out  8x64 signed  to loeffler_idct idct_in, sign-extended
idct_valid_out  in  1  from loeffler_idct valid_out
idct_channel_out  in  CH_W  from loeffler_idct channel_out
idct_out  in  8x64 signed  from loeffler_idct idct_out
out_valid  out  1  pixel row valid
out_ready  in  1  pixel row consumed when out_valid && out_ready
out_row  out  8*8  8 unsigned pixels, 0..255
out_ch  out  CH_W  channel of the current block
out_last  out  1  high with pixel row 7
err  out  1  sticky error; tied to 0 unless the optional feature is compiled in

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- FSM states: IDLE, ROW, ROW_WAIT, COL, COL_WAIT, OUT.
- IDLE: in_ready=1. On accept:
  - latch in_ch;
  - drive row 0 to the IDCT (idct_valid_in=1 for 1 cycle, registered);
  - issue_cnt=1; go to ROW.
- ROW: in_ready=1. Each accepted row r is issued to the IDCT the next cycle. After row 7 is accepted, go to ROW_WAIT. in_ready drops the cycle after row 7 is accepted.
- Issue timing: idct_valid_in is asserted only in the cycle following an accept or a column issue; otherwise it is 0.
- Capture during ROW and ROW_WAIT:
  - Each idct_valid_out writes tbuf[cap_cnt][c] = sat_MID_W(idct_out[c]), then cap_cnt++.
  - Captures in ROW may overlap issues.
  - When cap_cnt reaches 8, go to COL and clear the counters.
- COL:
  - Issue column c (tbuf[0..7][c], sign-extended) on 8 consecutive cycles, c=0..7.
  - idct_channel_in = latched channel.
  - Then go to COL_WAIT.
- Capture during COL and COL_WAIT:
  - Each idct_valid_out for column c writes obuf[r][c] = clamp(((idct_out[r] + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT) + 128, 0, 255), where c = capture index.
  - After 8 captures, go to OUT.
- OUT:
  - out_valid=1, out_row=obuf[k], k=0..7; advances on each handshake.
  - out_last=1 when k=7.
  - The handshake with k=7 returns to IDLE.
  - out_row and out_valid are held stable while out_ready=0.
- Throughput: one block per ≥ 8+L+8+L+8 cycles (L = IDCT latency). No overlap between blocks; in_ready=0 outside IDLE/ROW.
- Saturation: sat_MID_W clamps to [-2^(MID_W-1), 2^(MID_W-1)-1].
- idct_valid_out in IDLE or OUT is ignored (no buffer write).
- Reset mid-block: all state is discarded immediately; buffer contents are don't-care; the next block starts fresh from IDLE.
- in_valid deasserting mid-ROW: the FSM holds in ROW, no issue occurs, and the row counter is retained.

Optional Feature:
IDCT2D_ERR_CHECK_EN. When defined:
- err sets and holds until reset on any of:
  - idct_valid_out outside ROW/ROW_WAIT/COL/COL_WAIT;
  - idct_channel_out not equal to the latched channel on a capture;
  - a WAIT state lasting more than TIMEOUT cycles, after which the FSM is forced to IDLE.
- Data flow is otherwise unchanged.

When undefined: err=0 constantly, no checking logic, and no timeout (the FSM waits forever).

Test Plan:
- Bench uses an identity stub IDCT (latency 3, passes channel through); OUT_SHIFT=3.
- All-zero block, in_ch=2 -> 8 rows of pixels all 128; out_ch=2; out_last only on row 7.
- in[r][c]=8*(r*8+c) -> pixel[r][c] = clamp(r*8+c+128) = 128..191 row-major. Confirms the transpose ordering cancels out.
- Element values +2047 and -2048 with stub gain 64 -> row results saturate to 32767/-32768. Pixels clamp to 255/0.
- out_ready toggling 1 cycle on, 2 cycles off during OUT -> each row emitted exactly once and stable while stalled; next block accepted only after the out_last handshake.
- rst pulled low for 1 cycle in COL_WAIT -> all outputs 0 immediately. A following zero block yields 8 rows of 128.
- With IDCT2D_ERR_CHECK_EN: stub returns channel 1 while latched channel is 0 -> err=1 from the next cycle and held. Stub made silent -> err=1 after 256 cycles in ROW_WAIT; FSM returns to IDLE.

Source files
------------

// File: rtl/idct2d_sched.sv
// 2D IDCT scheduler: row pass, transpose, column pass, round/level-shift/clamp.
// Define IDCT2D_ERR_CHECK_EN for a sticky err with channel/stray/timeout checks.
module idct2d_sched #(
   parameter int IN_W      = 12,
   parameter int MID_W     = 16,
   parameter int OUT_SHIFT = 3,
   parameter int CH_W      = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*IN_W-1:0]   in_row,
   input  logic [CH_W-1:0]     in_ch,
   output logic                idct_valid_in,
   output logic [CH_W-1:0]     idct_channel_in,
   output logic [7:0][63:0]    idct_in,
   input  logic                idct_valid_out,
   input  logic [CH_W-1:0]     idct_channel_out,
   input  logic [7:0][63:0]    idct_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [63:0]         out_row,
   output logic [CH_W-1:0]     out_ch,
   output logic                out_last,
   output logic                err
);
   typedef enum logic [2:0] {IDLE, ROW, ROW_WAIT, COL, COL_WAIT, OUT} state_t;

   localparam logic signed [63:0] SMAX = (64'sd1 <<< (MID_W - 1)) - 64'sd1;
   localparam logic signed [63:0] SMIN = -(64'sd1 <<< (MID_W - 1));
   localparam logic signed [63:0] RND  = 64'sd1 <<< (OUT_SHIFT - 1);

   function automatic logic [63:0] sx_in(input logic [IN_W-1:0] v);
      return {{(64-IN_W){v[IN_W-1]}}, v};
   endfunction

   function automatic logic [63:0] sx_mid(input logic [MID_W-1:0] v);
      return {{(64-MID_W){v[MID_W-1]}}, v};
   endfunction

   function automatic logic [MID_W-1:0] sat(input logic [63:0] v);
      logic signed [63:0] t;
      t = $signed(v);
      if (t > SMAX) t = SMAX;
      else if (t < SMIN) t = SMIN;
      return t[MID_W-1:0];
   endfunction

   function automatic logic [7:0] pix(input logic [63:0] v);
      logic signed [63:0] t;
      t = ($signed(v) + RND) >>> OUT_SHIFT;
      t = t + 64'sd128;
      if (t < 64'sd0) return 8'd0;
      if (t > 64'sd255) return 8'd255;
      return t[7:0];
   endfunction

   state_t            state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d, cin_q, cin_d;
   logic [2:0]        iss_q, iss_d, cap_q, cap_d, k_q, k_d;
   logic              rdy_q, rdy_d, vin_q, vin_d;
   logic              ov_q, ov_d, ol_q, ol_d;
   logic [7:0][63:0]  din_q, din_d;
   logic [MID_W-1:0]  tbuf [8][8];
   logic [7:0]        obuf [8][8];
   logic              acc, tb_we, ob_we;

   assign acc   = in_valid && rdy_q;
   assign tb_we = idct_valid_out && (state_q == ROW || state_q == ROW_WAIT);
   assign ob_we = idct_valid_out && (state_q == COL || state_q == COL_WAIT);

`ifdef IDCT2D_ERR_CHECK_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic          err_q, err_d;
   logic [TW-1:0] wcnt_q, wcnt_d;
`endif

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      cin_d   = cin_q;
      iss_d   = iss_q;
      cap_d   = cap_q;
      k_d     = k_q;
      vin_d   = 1'b0;
      din_d   = din_q;
      ov_d    = ov_q;
      ol_d    = ol_q;
      case (state_q)
         IDLE: if (acc) begin
            ch_d    = in_ch;
            cin_d   = in_ch;
            vin_d   = 1'b1;
            for (int c = 0; c < 8; c++) din_d[c] = sx_in(in_row[c*IN_W +: IN_W]);
            iss_d   = 3'd1;
            cap_d   = 3'd0;
            state_d = ROW;
         end
         ROW: begin
            if (acc) begin
               cin_d = ch_q;
               vin_d = 1'b1;
               for (int c = 0; c < 8; c++) din_d[c] = sx_in(in_row[c*IN_W +: IN_W]);
               iss_d = iss_q + 3'd1;
               if (iss_q == 3'd7) state_d = ROW_WAIT;
            end
            if (tb_we) cap_d = cap_q + 3'd1;
         end
         ROW_WAIT: if (tb_we) begin
            cap_d = cap_q + 3'd1;
            if (cap_q == 3'd7) begin
               state_d = COL;
               cap_d   = 3'd0;
               iss_d   = 3'd0;
            end
         end
         COL: begin
            cin_d = ch_q;
            vin_d = 1'b1;
            for (int r = 0; r < 8; r++) din_d[r] = sx_mid(tbuf[r][iss_q]);
            iss_d = iss_q + 3'd1;
            if (iss_q == 3'd7) state_d = COL_WAIT;
            if (ob_we) cap_d = cap_q + 3'd1;
         end
         COL_WAIT: if (ob_we) begin
            cap_d = cap_q + 3'd1;
            if (cap_q == 3'd7) begin
               state_d = OUT;
               cap_d   = 3'd0;
               k_d     = 3'd0;
               ov_d    = 1'b1;
               ol_d    = 1'b0;
            end
         end
         OUT: if (out_ready) begin
            if (k_q == 3'd7) begin
               state_d = IDLE;
               k_d     = 3'd0;
               ov_d    = 1'b0;
               ol_d    = 1'b0;
            end else begin
               k_d  = k_q + 3'd1;
               ol_d = (k_q == 3'd6);
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef IDCT2D_ERR_CHECK_EN
      err_d  = err_q;
      wcnt_d = '0;
      if (idct_valid_out && (state_q == IDLE || state_q == OUT))
         err_d = 1'b1;
      if ((tb_we || ob_we) && idct_channel_out != ch_q)
         err_d = 1'b1;
      // A stalled IDCT abandons the block rather than hanging the pipe.
      if ((state_q == ROW_WAIT || state_q == COL_WAIT) && state_d == state_q) begin
         wcnt_d = wcnt_q + 1'b1;
         if (wcnt_q == TW'(TIMEOUT)) begin
            err_d   = 1'b1;
            wcnt_d  = '0;
            state_d = IDLE;
         end
      end
`endif
      rdy_d = (state_d == IDLE) || (state_d == ROW);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ch_q    <= '0;
         cin_q   <= '0;
         iss_q   <= '0;
         cap_q   <= '0;
         k_q     <= '0;
         rdy_q   <= 1'b0;
         vin_q   <= 1'b0;
         din_q   <= '0;
         ov_q    <= 1'b0;
         ol_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         cin_q   <= cin_d;
         iss_q   <= iss_d;
         cap_q   <= cap_d;
         k_q     <= k_d;
         rdy_q   <= rdy_d;
         vin_q   <= vin_d;
         din_q   <= din_d;
         ov_q    <= ov_d;
         ol_q    <= ol_d;
      end
   end

   // Row results land as tbuf rows; column results land as obuf columns.
   always_ff @(posedge clk) begin
      if (tb_we)
         for (int c = 0; c < 8; c++) tbuf[cap_q][c] <= sat(idct_out[c]);
      if (ob_we)
         for (int r = 0; r < 8; r++) obuf[r][cap_q] <= pix(idct_out[r]);
   end

   always_comb begin
      out_row = '0;
      if (ov_q)
         for (int c = 0; c < 8; c++) out_row[c*8 +: 8] = obuf[k_q][c];
   end

`ifdef IDCT2D_ERR_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q  <= 1'b0;
         wcnt_q <= '0;
      end else begin
         err_q  <= err_d;
         wcnt_q <= wcnt_d;
      end
   end
   assign err = err_q;
`else
   logic unused_err;
   assign unused_err = ^{idct_channel_out, TIMEOUT[0]};
   assign err = 1'b0;
`endif

   assign in_ready        = rdy_q;
   assign idct_valid_in   = vin_q;
   assign idct_channel_in = cin_q;
   assign idct_in         = din_q;
   assign out_valid       = ov_q;
   assign out_last        = ol_q;
   assign out_ch          = ch_q;
endmodule

// File: tb/tb_idct2d_sched.sv
// Scoreboard bench for idct2d_sched with a latency-3 scaling stub IDCT.
// Driver pushes expected pixel rows; a negedge monitor pops and compares.
module tb_idct2d_sched;
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid, in_ready;
   logic [95:0]      in_row;
   logic [1:0]       in_ch;
   logic             idct_valid_in, idct_valid_out;
   logic [1:0]       idct_channel_in, idct_channel_out;
   logic [7:0][63:0] idct_in, idct_out;
   logic             out_valid, out_ready, out_last, err;
   logic [63:0]      out_row;
   logic [1:0]       out_ch;

   always #5 clk = ~clk;

   idct2d_sched dut (
      .clk(clk), .rst(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_row(in_row), .in_ch(in_ch),
      .idct_valid_in(idct_valid_in), .idct_channel_in(idct_channel_in),
      .idct_in(idct_in),
      .idct_valid_out(idct_valid_out), .idct_channel_out(idct_channel_out),
      .idct_out(idct_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
      .out_ch(out_ch), .out_last(out_last), .err(err)
   );

   longint           gain = 1;
   logic             silent = 1'b0;
   logic             ch_ovr_en = 1'b0;
   logic [1:0]       ch_ovr = 2'd0;
   logic [2:0]       sv = '0;
   logic [1:0]       sc [3] = '{default: '0};
   logic [7:0][63:0] sd [3] = '{default: '0};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) sv <= '0;
      else begin
         sv    <= {sv[1:0], idct_valid_in & ~silent};
         sc[0] <= ch_ovr_en ? ch_ovr : idct_channel_in;
         sc[1] <= sc[0];
         sc[2] <= sc[1];
         for (int i = 0; i < 8; i++) sd[0][i] <= $signed(idct_in[i]) * gain;
         sd[1] <= sd[0];
         sd[2] <= sd[1];
      end
   end
   assign idct_valid_out   = sv[2];
   assign idct_channel_out = sc[2];
   assign idct_out         = sd[2];

   typedef struct {
      logic [63:0] row;
      logic [1:0]  ch;
      logic        last;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   int          nvec = 0;
   int          nmis = 0;
   int          iss_cnt = 0;
   int          ph = 0;
   bit          stall_mode = 1'b0;
   bit          stalled = 1'b0;
   logic [63:0] prev_row;
   logic [95:0] blk [8];
   logic [63:0] exr [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) if (rst_n && idct_valid_in) iss_cnt++;

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_mode) begin
            ph = (ph + 1) % 3;
            out_ready = (ph == 0);
         end else out_ready = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) stalled = 1'b0;
      else begin
         if (out_valid) begin
            chk("in_ready_in_out", 64'(in_ready), 64'd0);
            if (stalled) chk("stall_stable", out_row, prev_row);
            if (out_ready) begin
               if (q.size() == 0) begin
                  nvec++;
                  nmis++;
                  $display("FAIL extra_row: got %h want none", out_row);
               end else begin
                  e = q.pop_front();
                  chk("pix_row", out_row, e.row);
                  chk("out_ch", 64'(out_ch), 64'(e.ch));
                  chk("out_last", 64'(out_last), 64'(e.last));
               end
            end
         end
         stalled  = out_valid && !out_ready;
         prev_row = out_row;
      end
   end

   task automatic rst_checks(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_out_last"}, 64'(out_last), 64'd0);
      chk({tag, "_out_row"}, out_row, 64'd0);
      chk({tag, "_out_ch"}, 64'(out_ch), 64'd0);
      chk({tag, "_idct_vin"}, 64'(idct_valid_in), 64'd0);
      chk({tag, "_idct_in"}, 64'(|{idct_in, idct_channel_in}), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
   endtask

   task automatic send_row(input logic [95:0] row, input logic [1:0] ch);
      int n = 0;
      in_valid = 1'b1;
      in_row   = row;
      in_ch    = ch;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 1000) begin
            nvec++;
            nmis++;
            $display("FAIL row_accept_timeout: got in_ready=0 want 1");
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_block(input logic [1:0] ch, input bit push, input int gap_after);
      iss_cnt = 0;
      if (push)
         for (int k = 0; k < 8; k++) q.push_back('{row: exr[k], ch: ch, last: (k == 7)});
      for (int r = 0; r < 8; r++) begin
         send_row(blk[r], ch);
         if (r == gap_after) begin
            repeat (4) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic drain(input string nm);
      int n = 0;
      forever begin
         @(negedge clk);
         if (q.size() == 0 && !out_valid) break;
         n++;
         if (n > 1000) begin
            nvec++;
            nmis++;
            $display("FAIL %s_drain_timeout: got %0d rows left want 0", nm, q.size());
            q.delete();
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic mk_zero();
      for (int r = 0; r < 8; r++) begin
         blk[r] = '0;
         exr[r] = {8{8'd128}};
      end
   endtask

   task automatic mk_ramp();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            blk[r][c*12 +: 12] = 12'(8 * (r * 8 + c));
            exr[r][c*8 +: 8]   = 8'(128 + r * 8 + c);
         end
   endtask

   task automatic mk_sat();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            blk[r][c*12 +: 12] = (c % 2 == 0) ? 12'h7FF : 12'h800;
            exr[r][c*8 +: 8]   = (c % 2 == 0) ? 8'hFF : 8'h00;
         end
   endtask

   initial begin
      in_valid = 1'b0;
      in_row   = '0;
      in_ch    = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_checks("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_in_ready", 64'(in_ready), 64'd1);

      mk_zero();
      send_block(2'd2, 1'b1, -1);
      drain("zero");

      mk_ramp();
      send_block(2'd1, 1'b1, 3);
      drain("ramp");

      gain = 64;
      mk_sat();
      send_block(2'd3, 1'b1, -1);
      drain("sat");
      gain = 1;

      stall_mode = 1'b1;
      mk_ramp();
      send_block(2'd0, 1'b1, -1);
      mk_zero();
      send_block(2'd2, 1'b1, -1);
      drain("stall");
      stall_mode = 1'b0;

      send_block(2'd2, 1'b0, -1);
      for (int n = 0; n < 200 && iss_cnt < 16; n++) begin
         @(negedge clk);
         #1;
      end
      chk("col_issues", 64'(iss_cnt), 64'd16);
      rst_n = 1'b0;
      #1;
      rst_checks("midrst");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      mk_zero();
      send_block(2'd1, 1'b1, -1);
      drain("postrst");

`ifdef IDCT2D_ERR_CHECK_EN
      ch_ovr_en = 1'b1;
      ch_ovr    = 2'd1;
      send_block(2'd0, 1'b1, -1);
      drain("errch");
      chk("err_chan_held", 64'(err), 64'd1);
      ch_ovr_en = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("err_cleared", 64'(err), 64'd0);
      silent = 1'b1;
      send_block(2'd0, 1'b0, -1);
      repeat (270) @(posedge clk);
      #1;
      chk("err_timeout", 64'(err), 64'd1);
      chk("timeout_idle", 64'(in_ready), 64'd1);
      silent = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
`else
      chk("err_tied_low", 64'(err), 64'd0);
`endif
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "global timeout");
   end
endmodule
